memory_writeback: RTL
=====================

// Module: memory_writeback
// PURPOSE
// - MEM/WB pipeline register and writeback select; sits directly downstream of Execute_Memory.
// - Captures ALU/FPU result (muxpal), data-memory ReadData, PC+4, ImmExt and dest/control fields.
// - Drives integer and float register-file write ports; supports stall/flush.
// - Keeps a retired-instruction counter.
// PARAMETERS
// - XLEN      32  datapath width of all data ports
// - REG_AW    5   register address width (rd)
// - CNT_W     32  width of retired-instruction counter
// PORTS
// - clk          in   1       rising-edge clock
// - rst_n        in   1       asynchronous active-low reset
// - stall        in   1       hold stage register contents
// - flush        in   1       insert bubble (clears valid)
// - in_valid     in   1       incoming instruction is valid
// - alu_fpu_res  in   XLEN    ALU/FPU select-mux result from Execute_Memory
// - read_data    in   XLEN    data-memory dout, already size/sign extended
// - pc_plus4     in   XLEN    link value for jal/jalr
// - imm_ext      in   XLEN    extended immediate (lui)
// - rd           in   REG_AW  destination register
// - result_src   in   2       00 alu_fpu_res, 01 read_data, 10 pc_plus4, 11 imm_ext
// - reg_write    in   1       write integer register file
// - freg_write   in   1       write float register file
// - wb_valid     out  1       stage holds a valid instruction
// - wb_rd        out  REG_AW  registered rd
// - wb_data      out  XLEN    selected writeback value
// - wb_we        out  1       integer RF write enable
// - wb_fwe       out  1       float RF write enable
// - instret      out  CNT_W   retired-instruction count
// BEHAVIOUR
// - Reset (rst_n=0, async): wb_valid=0, wb_rd=0, all captured data=0, result_src=00,
//   wb_we=0, wb_fwe=0, wb_data=0, instret=0. Outputs hold these values until first capture.
// - Priority at each posedge clk: flush > stall > capture.
// - flush=1: valid cleared, reg_write/freg_write cleared; data fields don't-care but are held.
// - stall=1, flush=0: every field holds; instret holds.
// - Otherwise: all inputs captured; valid<=in_valid.
// - Latency: 1 cycle from inputs to wb_* outputs; wb_data is combinational from registered fields.
// - wb_we  = valid & reg_write_q  & (rd_q != 0)  (x0 never written).
// - wb_fwe = valid & freg_write_q (f0 is writable).
// - reg_write and freg_write both set: both enables assert with the same wb_data.
// - instret +1 at a posedge where stall=0, flush=0, in_valid=1. Wraps 2^CNT_W-1 -> 0 silently.
// - Bubble (valid=0): wb_we=wb_fwe=0 regardless of captured control.
// - Reset deasserted mid-operation: first capture on the next posedge with stall=0.
// CONFIGURATION
// - MEMWB_FWD_EN defined: adds inputs rs1_ex, rs2_ex (REG_AW) and outputs fwd_a, fwd_b (1 bit):
//   fwd_x = wb_we & (wb_rd == rsx_ex) | wb_fwe & (wb_rd == rsx_ex), combinational;
//   forwarded value is wb_data.
// - MEMWB_FWD_EN undefined: these ports are absent; hazards resolved by stalls upstream.
// TESTING
// - Reset: rst_n=0 mid-cycle -> all outputs 0 immediately, instret=0.
// - ALU op: in_valid=1, rd=5, result_src=00, alu_fpu_res=32'h0000_00A5, reg_write=1
//   -> next cycle wb_we=1, wb_rd=5, wb_data=32'hA5, instret=1.
// - Load to x0: rd=0, result_src=01, read_data=32'hFFFF_FF80, reg_write=1
//   -> wb_we=0, wb_valid=1, wb_data=32'hFFFF_FF80.
// - FP load + stall: freg_write=1, rd=3, then stall=1 for 2 cycles with new inputs
//   -> wb_fwe=1, wb_rd=3 held 3 cycles; instret unchanged during stall.
// - Flush with stall: stall=1, flush=1 -> wb_valid=0, wb_we=0, wb_fwe=0, instret unchanged.
// - Wrap: force instret=32'hFFFF_FFFF, one valid capture -> instret=0;
//   with MEMWB_FWD_EN, wb_rd=7, wb_we=1, rs1_ex=7 -> fwd_a=1, fwd_b=0.

Source files
------------

// File: rtl/memory_writeback_if.sv
// MEM/WB stage bundle: upstream capture fields in, writeback ports and retire count out.
// MEMWB_FWD_EN adds the EX-stage source register compare used for forwarding.
interface memory_writeback_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              stall;
    logic              flush;
    logic              in_valid;
    logic [XLEN-1:0]   alu_fpu_res;
    logic [XLEN-1:0]   read_data;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   imm_ext;
    logic [REG_AW-1:0] rd;
    logic [1:0]        result_src;
    logic              reg_write;
    logic              freg_write;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              wb_we;
    logic              wb_fwe;
    logic [CNT_W-1:0]  instret;
`ifdef MEMWB_FWD_EN
    logic [REG_AW-1:0] rs1_ex;
    logic [REG_AW-1:0] rs2_ex;
    logic              fwd_a;
    logic              fwd_b;
`endif

    modport master (
`ifdef MEMWB_FWD_EN
        output rs1_ex, rs2_ex,
        input  fwd_a, fwd_b,
`endif
        output stall, flush, in_valid, alu_fpu_res, read_data, pc_plus4, imm_ext,
               rd, result_src, reg_write, freg_write,
        input  wb_valid, wb_rd, wb_data, wb_we, wb_fwe, instret
    );

    modport slave (
`ifdef MEMWB_FWD_EN
        input  rs1_ex, rs2_ex,
        output fwd_a, fwd_b,
`endif
        input  stall, flush, in_valid, alu_fpu_res, read_data, pc_plus4, imm_ext,
               rd, result_src, reg_write, freg_write,
        output wb_valid, wb_rd, wb_data, wb_we, wb_fwe, instret
    );
endinterface

// File: rtl/memory_writeback.sv
// MEM/WB pipeline register with writeback select and retired-instruction counter.
// Optional MEMWB_FWD_EN: combinational forwarding match against EX-stage rs1/rs2.
module memory_writeback #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input logic                clk,
    input logic                rst_n,
    memory_writeback_if.slave  wbIf
);
    logic              validQ;
    logic [REG_AW-1:0] rdQ;
    logic [XLEN-1:0]   aluFpuQ;
    logic [XLEN-1:0]   readDataQ;
    logic [XLEN-1:0]   pcPlus4Q;
    logic [XLEN-1:0]   immExtQ;
    logic [1:0]        resultSrcQ;
    logic              regWriteQ;
    logic              fregWriteQ;
    logic [CNT_W-1:0]  instretQ;
    logic [XLEN-1:0]   wbData;
    logic              wbWe;
    logic              wbFwe;

    // Flush only kills valid and the write enables; payload is left in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validQ     <= 1'b0;
            rdQ        <= '0;
            aluFpuQ    <= '0;
            readDataQ  <= '0;
            pcPlus4Q   <= '0;
            immExtQ    <= '0;
            resultSrcQ <= 2'b00;
            regWriteQ  <= 1'b0;
            fregWriteQ <= 1'b0;
            instretQ   <= '0;
        end else if (wbIf.flush) begin
            validQ     <= 1'b0;
            regWriteQ  <= 1'b0;
            fregWriteQ <= 1'b0;
        end else if (!wbIf.stall) begin
            validQ     <= wbIf.in_valid;
            rdQ        <= wbIf.rd;
            aluFpuQ    <= wbIf.alu_fpu_res;
            readDataQ  <= wbIf.read_data;
            pcPlus4Q   <= wbIf.pc_plus4;
            immExtQ    <= wbIf.imm_ext;
            resultSrcQ <= wbIf.result_src;
            regWriteQ  <= wbIf.reg_write;
            fregWriteQ <= wbIf.freg_write;
            if (wbIf.in_valid) begin
                instretQ <= instretQ + 1'b1;
            end
        end
    end

    always_comb begin
        wbData = aluFpuQ;
        unique case (resultSrcQ)
            2'b00: wbData = aluFpuQ;
            2'b01: wbData = readDataQ;
            2'b10: wbData = pcPlus4Q;
            2'b11: wbData = immExtQ;
            default: wbData = aluFpuQ;
        endcase
    end

    // x0 is hardwired zero in the integer file; f0 is an ordinary register.
    assign wbWe  = validQ & regWriteQ & (rdQ != '0);
    assign wbFwe = validQ & fregWriteQ;

    assign wbIf.wb_valid = validQ;
    assign wbIf.wb_rd    = rdQ;
    assign wbIf.wb_data  = wbData;
    assign wbIf.wb_we    = wbWe;
    assign wbIf.wb_fwe   = wbFwe;
    assign wbIf.instret  = instretQ;

`ifdef MEMWB_FWD_EN
    assign wbIf.fwd_a = (wbWe | wbFwe) & (rdQ == wbIf.rs1_ex);
    assign wbIf.fwd_b = (wbWe | wbFwe) & (rdQ == wbIf.rs2_ex);
`endif
endmodule
